// File: rtl/pq_cmd_pkg.sv
// Shared types and sizing helpers for the priority-queue command scheduler.
package pq_cmd_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REP} pq_op_t;

  typedef enum logic {IDLE, WAIT} sched_state_t;

  // Wait counter must hold the larger of the two settle times; never narrower than 1 bit.
  function automatic int wait_cnt_width(input int enq_wait, input int op_wait);
    int m;
    m = (enq_wait > op_wait) ? enq_wait : op_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pq_cmd_fifo.sv
// Small synchronous push buffer with a combinational head so the scheduler
// can decide on the oldest key in the same cycle it becomes visible.
module pq_cmd_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_rd   = rd_en && !empty;
  // A write while full is only safe when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pq_cmd_scheduler.sv
// Command stage in front of the sorted-register priority queue: buffers pushes,
// merges push+pop into replace, spaces strobes by the queue settle time.
module pq_cmd_scheduler
  import pq_cmd_pkg::*;
#(
  parameter int QUEUE_SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ENQ_WAIT   = QUEUE_SIZE / 2,
  parameter int OP_WAIT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop_valid,
  output logic                  o_pop_ready,
  output logic                  o_pop_valid,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_pop_empty,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data
);

  localparam int              CNT_W    = wait_cnt_width(ENQ_WAIT, OP_WAIT);
  localparam logic [CNT_W-1:0] ENQ_LOAD = CNT_W'(ENQ_WAIT);
  localparam logic [CNT_W-1:0] OP_LOAD  = CNT_W'(OP_WAIT);

  sched_state_t          state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  pop_pending_reg;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  push_fire, pop_fire;
  pq_op_t                op;
  logic                  empty_pop;
  logic [CNT_W-1:0]      wait_load;

  assign o_push_ready = !fifo_full;
  assign o_pop_ready  = !pop_pending_reg;
  assign push_fire    = i_push_valid && o_push_ready;
  assign pop_fire     = i_pop_valid && o_pop_ready;
  assign fifo_pop     = (op == OP_ENQ) || (op == OP_REP);
  assign wait_load    = (op == OP_ENQ) ? ENQ_LOAD : OP_LOAD;

  pq_cmd_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (i_CLK),
    .rst_n  (i_RSTn),
    .wr_en  (push_fire),
    .wr_data(i_push_data),
    .rd_en  (fifo_pop),
    .rd_data(fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (op != OP_NONE) begin
          cnt_next   = wait_load;
          state_next = (wait_load == '0) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        // The strobe cycle itself is the first WAIT cycle, so leave as the count hits 0.
        cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decision; a pending pop with a queued push and an empty queue falls through to enqueue.
  always_comb begin
    op        = OP_NONE;
    empty_pop = 1'b0;
    if (state_reg == IDLE) begin
      if (pop_pending_reg && !fifo_empty && !i_pq_empty) begin
        op = OP_REP;
      end else if (pop_pending_reg && fifo_empty) begin
        if (!i_pq_empty) op = OP_DEQ;
        else             empty_pop = 1'b1;
      end else if (!fifo_empty && !i_pq_full) begin
        op = OP_ENQ;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      pop_pending_reg <= 1'b0;
      o_pq_wrt        <= 1'b0;
      o_pq_read       <= 1'b0;
      o_pq_data       <= '0;
      o_pop_valid     <= 1'b0;
      o_pop_data      <= '0;
      o_pop_empty     <= 1'b0;
    end else begin
      o_pq_wrt  <= (op == OP_ENQ) || (op == OP_REP);
      o_pq_read <= (op == OP_DEQ) || (op == OP_REP);
      if (fifo_pop) o_pq_data <= fifo_head;

      if (pop_fire)
        pop_pending_reg <= 1'b1;
      else if ((op == OP_DEQ) || (op == OP_REP) || empty_pop)
        pop_pending_reg <= 1'b0;

      // During the read strobe the queue still shows the pre-operation top.
      o_pop_valid <= o_pq_read || empty_pop;
      if (o_pq_read) begin
        o_pop_data  <= i_pq_data;
        o_pop_empty <= 1'b0;
      end else if (empty_pop) begin
        o_pop_data  <= '0;
        o_pop_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pq_cmd_scheduler.sv
// Scoreboard bench for pq_cmd_scheduler driving a behavioural sorted max-first queue.
module tb_pq_cmd_scheduler;

  localparam int DW = 16;
  localparam int QS = 8;
  localparam int EW = 4;
  localparam int OW = 1;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_push_valid, i_pop_valid;
  logic [DW-1:0] i_push_data;
  logic          o_push_ready, o_pop_ready, o_pop_valid, o_pop_empty;
  logic [DW-1:0] o_pop_data, o_pq_data;
  logic          o_pq_wrt, o_pq_read;
  logic          pq_full, pq_empty;
  logic [DW-1:0] pq_top;

  always #5 clk = ~clk;

  pq_cmd_scheduler #(
    .QUEUE_SIZE(QS), .DATA_WIDTH(DW), .ENQ_WAIT(EW), .OP_WAIT(OW), .FIFO_DEPTH(FD)
  ) dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_push_valid(i_push_valid), .o_push_ready(o_push_ready), .i_push_data(i_push_data),
    .i_pop_valid(i_pop_valid), .o_pop_ready(o_pop_ready),
    .o_pop_valid(o_pop_valid), .o_pop_data(o_pop_data), .o_pop_empty(o_pop_empty),
    .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
    .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_top)
  );

  // Behavioural load: sorted register array, largest key at index 0.
  typedef logic [DW-1:0] qarr_t [QS];
  qarr_t q_mem;
  int    q_cnt;

  function automatic qarr_t q_remove_top(input qarr_t a);
    qarr_t r;
    for (int i = 0; i < QS - 1; i++) r[i] = a[i+1];
    r[QS-1] = '0;
    return r;
  endfunction

  function automatic qarr_t q_insert(input qarr_t a, input int n, input logic [DW-1:0] d);
    qarr_t r;
    int pos;
    r = a;
    pos = n;
    for (int i = n - 1; i >= 0; i--) if (a[i] < d) pos = i;
    for (int i = QS - 1; i > pos; i--) r[i] = a[i-1];
    if (pos < QS) r[pos] = d;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem <= '{default: '0};
      q_cnt <= 0;
    end else if (o_pq_wrt && o_pq_read && q_cnt > 0) begin
      q_mem <= q_insert(q_remove_top(q_mem), q_cnt - 1, o_pq_data);
    end else if (o_pq_wrt && !o_pq_read && q_cnt < QS) begin
      q_mem <= q_insert(q_mem, q_cnt, o_pq_data);
      q_cnt <= q_cnt + 1;
    end else if (o_pq_read && !o_pq_wrt && q_cnt > 0) begin
      q_mem <= q_remove_top(q_mem);
      q_cnt <= q_cnt - 1;
    end
  end

  assign pq_full  = (q_cnt == QS);
  assign pq_empty = (q_cnt == 0);
  assign pq_top   = q_mem[0];

  // Scoreboard
  typedef struct {logic wrt; logic rd; logic [DW-1:0] data;} strobe_t;
  typedef struct {logic empty; logic [DW-1:0] data; int cyc;} res_t;
  strobe_t exp_strobe[$];
  res_t    exp_res[$];
  int      strobe_cycles[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  int      last_strobe_cyc = -100;
  int      last_gap_req = 0;
  strobe_t s;
  res_t    r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_s(input logic w, input logic rd, input logic [DW-1:0] d);
    exp_strobe.push_back('{wrt: w, rd: rd, data: d});
  endtask

  task automatic exp_r(input logic e, input logic [DW-1:0] d, input int c);
    exp_res.push_back('{empty: e, data: d, cyc: c});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && (o_pq_wrt || o_pq_read)) begin
      if (exp_strobe.size() == 0) begin
        check("unexpected_strobe", {30'd0, o_pq_wrt, o_pq_read}, 0);
      end else begin
        s = exp_strobe.pop_front();
        check("strobe_wrt", o_pq_wrt, s.wrt);
        check("strobe_read", o_pq_read, s.rd);
        if (s.wrt) check("strobe_data", o_pq_data, s.data);
      end
      check("strobe_spacing", (cyc - last_strobe_cyc) >= last_gap_req, 1);
      last_gap_req    = (o_pq_wrt && !o_pq_read) ? EW + 1 : OW + 1;
      last_strobe_cyc = cyc;
      strobe_cycles.push_back(cyc);
    end
    if (rst_n && o_pop_valid) begin
      if (exp_res.size() == 0) begin
        check("unexpected_result", o_pop_valid, 0);
      end else begin
        r = exp_res.pop_front();
        check("result_empty", o_pop_empty, r.empty);
        check("result_data", o_pop_data, r.data);
        check("result_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic push(input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    i_push_valid = 1'b1;
    i_push_data  = d;
    while (!o_push_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", o_push_ready, 1);
    @(posedge clk);
    #1 i_push_valid = 1'b0;
  endtask

  task automatic pop(output int acc);
    int n;
    n = 0;
    @(negedge clk);
    i_pop_valid = 1'b1;
    while (!o_pop_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("pop_timeout", o_pop_ready, 1);
    @(posedge clk);
    #1 i_pop_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic pop_push(input logic [DW-1:0] d, output int acc);
    @(negedge clk);
    check("merge_ready", {30'd0, o_push_ready, o_pop_ready}, 3);
    i_pop_valid  = 1'b1;
    i_push_valid = 1'b1;
    i_push_data  = d;
    @(posedge clk);
    #1;
    i_pop_valid  = 1'b0;
    i_push_valid = 1'b0;
    acc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, sc, s0, n0;
    i_push_valid = 1'b0;
    i_pop_valid  = 1'b0;
    i_push_data  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {29'd0, o_pq_wrt, o_pq_read, o_pop_valid}, 0);
    check("rst_ready", {30'd0, o_push_ready, o_pop_ready}, 3);
    check("rst_pop_data", o_pop_data, 0);
    check("rst_pq_data", o_pq_data, 0);
    check("rst_pop_empty", o_pop_empty, 0);
    rst_n = 1'b1;

    // Reset in the middle of the enqueue wait.
    exp_s(1'b1, 1'b0, 16'd1);
    push(16'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", {29'd0, o_pq_wrt, o_pq_read, o_pop_valid}, 0);
    check("midrst_ready", {30'd0, o_push_ready, o_pop_ready}, 3);
    last_strobe_cyc = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sc = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (o_pq_wrt || o_pq_read) sc++;
    end
    check("post_reset_no_strobe", sc, 0);

    // Back-to-back pushes: enqueue strobes exactly ENQ_WAIT+1 apart.
    s0 = strobe_cycles.size();
    exp_s(1'b1, 1'b0, 16'd5);
    exp_s(1'b1, 1'b0, 16'd9);
    exp_s(1'b1, 1'b0, 16'd3);
    push(16'd5);
    push(16'd9);
    push(16'd3);
    repeat (20) @(negedge clk);
    check("b2b_strobe_count", strobe_cycles.size() - s0, 3);
    if (strobe_cycles.size() - s0 == 3) begin
      check("b2b_gap1", strobe_cycles[s0+1] - strobe_cycles[s0], 5);
      check("b2b_gap2", strobe_cycles[s0+2] - strobe_cycles[s0+1], 5);
    end
    check("b2b_top", pq_top, 9);

    // Dequeue returns the top.
    exp_s(1'b0, 1'b1, 16'd0);
    pop(acc);
    exp_r(1'b0, 16'd9, acc + 2);
    repeat (10) @(negedge clk);
    check("deq_new_top", pq_top, 5);

    // Merged replace returns the pre-insert top.
    exp_s(1'b1, 1'b0, 16'd9);
    push(16'd9);
    repeat (10) @(negedge clk);
    exp_s(1'b1, 1'b1, 16'd7);
    pop_push(16'd7, acc);
    exp_r(1'b0, 16'd9, acc + 2);
    repeat (10) @(negedge clk);
    check("rep_count", q_cnt, 3);
    check("rep_q0", q_mem[0], 7);
    check("rep_q1", q_mem[1], 5);
    check("rep_q2", q_mem[2], 3);

    // Drain, then pop an empty queue.
    exp_s(1'b0, 1'b1, 16'd0); pop(acc); exp_r(1'b0, 16'd7, acc + 2); repeat (8) @(negedge clk);
    exp_s(1'b0, 1'b1, 16'd0); pop(acc); exp_r(1'b0, 16'd5, acc + 2); repeat (8) @(negedge clk);
    exp_s(1'b0, 1'b1, 16'd0); pop(acc); exp_r(1'b0, 16'd3, acc + 2); repeat (8) @(negedge clk);
    pop(acc);
    exp_r(1'b1, 16'd0, acc + 1);
    repeat (6) @(negedge clk);

    // Fill the queue, then overfill the push buffer.
    for (int i = 0; i < QS; i++) begin
      exp_s(1'b1, 1'b0, DW'(10 + i));
      push(DW'(10 + i));
    end
    repeat (30) @(negedge clk);
    check("fill_full", pq_full, 1);
    n0 = strobe_cycles.size();
    for (int i = 0; i < 4; i++) push(DW'(20 + i));
    @(negedge clk);
    i_push_valid = 1'b1;
    i_push_data  = 16'd24;
    repeat (4) begin
      check("push_ready_full", o_push_ready, 0);
      @(negedge clk);
    end
    i_push_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("held_no_strobe", strobe_cycles.size() - n0, 0);

    // A pop releases the oldest buffered key as a replace.
    exp_s(1'b1, 1'b1, 16'd20);
    pop(acc);
    exp_r(1'b0, 16'd17, acc + 2);
    repeat (3) @(negedge clk);
    check("push_ready_back", o_push_ready, 1);
    repeat (5) @(negedge clk);
    exp_s(1'b1, 1'b1, 16'd21); pop(acc); exp_r(1'b0, 16'd20, acc + 2); repeat (8) @(negedge clk);
    exp_s(1'b1, 1'b1, 16'd22); pop(acc); exp_r(1'b0, 16'd21, acc + 2); repeat (8) @(negedge clk);
    exp_s(1'b1, 1'b1, 16'd23); pop(acc); exp_r(1'b0, 16'd22, acc + 2); repeat (10) @(negedge clk);
    check("final_top", pq_top, 23);
    check("strobes_outstanding", exp_strobe.size(), 0);
    check("results_outstanding", exp_res.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pq_cmd_scheduler.md
# pq_cmd_scheduler

Upstream command stage for the `RegisterArray` priority queue (max-first, sorted register array). It accepts independent push and pop request streams and buffers pushes in a small FIFO. It merges a coincident push and pop into one replace and issues single-cycle `wrt`/`read` strobes to the queue. Between strobes it enforces the queue's settle time, and it returns popped values on a result port.

## Interface
Parameters:
- `QUEUE_SIZE`, 8: depth of the downstream queue.
- `DATA_WIDTH`, 16: key width.
- `ENQ_WAIT`, `QUEUE_SIZE/2`: idle cycles required after an enqueue strobe.
- `OP_WAIT`, 1: idle cycles required after a dequeue or replace strobe.
- `FIFO_DEPTH`, 4: push buffer entries (power of two, ≥2).

Ports:
- `i_CLK` in 1: clock.
- `i_RSTn` in 1: asynchronous active-low reset.
- `i_push_valid` in 1, `o_push_ready` out 1, `i_push_data` in DATA_WIDTH: push request, valid/ready.
- `i_pop_valid` in 1, `o_pop_ready` out 1: pop request, valid/ready.
- `o_pop_valid` out 1: one-cycle pulse; a pop result is on `o_pop_data`.
- `o_pop_data` out DATA_WIDTH: popped key, held until the next result.
- `o_pop_empty` out 1: qualifies `o_pop_valid`; the pop found the queue empty.
- `o_pq_wrt`, `o_pq_read` out 1: strobes to the queue `i_wrt`/`i_read`.
- `o_pq_data` out DATA_WIDTH: to queue `i_data`.
- `i_pq_full`, `i_pq_empty` in 1: from queue `o_full`/`o_empty`.
- `i_pq_data` in DATA_WIDTH: from queue `o_data`, the current top.

## Operation
- **Push FIFO:** accepts when `i_push_valid && o_push_ready`; `o_push_ready = !fifo_full`.
- **Pop slot:** a single pending-pop flag; `o_pop_ready = !pop_pending`, so at most one pop is outstanding.
- **States:** `IDLE` and `WAIT`. In `WAIT` a down-counter runs from the loaded wait value to 0, then the block returns to `IDLE`. No strobe is driven in `WAIT`.
- **Decision in `IDLE`**, evaluated on registered state in priority order:
  1. **Replace:** `pop_pending && fifo_nonempty && !i_pq_empty` → wrt=1, read=1, data=FIFO head. Pop FIFO, clear pop_pending, load `OP_WAIT`.
  2. **Enqueue first:** `pop_pending && fifo_nonempty && i_pq_empty` → enqueue (rule 4); the pop is served afterwards.
  3. **Dequeue:** `pop_pending && !fifo_nonempty`:
     - If `!i_pq_empty`: read=1, clear pop_pending, load `OP_WAIT`.
     - If empty: no strobe; emit the result with `o_pop_empty=1` and data 0, clear pop_pending, stay `IDLE`.
  4. **Enqueue:** `fifo_nonempty && !i_pq_full` → wrt=1, data=FIFO head. Pop FIFO, load `ENQ_WAIT`.
  5. **Otherwise:** idle. A push is held while `i_pq_full` until a pop arrives, at which point rule 1 applies.
- **Result capture:** on a read or replace strobe, capture `i_pq_data` (the top before the operation). A replace therefore always returns the pre-insert top, even when the pushed key is larger.
- **Arrivals:** a request accepted in the same cycle as an `IDLE` decision is not visible until the next cycle.

## Timing
- **Strobes:** registered, high exactly one cycle.
  - After an enqueue strobe in cycle T, the next strobe is at T+1+`ENQ_WAIT` or later.
  - After a read or replace strobe, the next strobe is at T+1+`OP_WAIT` or later.
- **Latency:** push accepted at T → earliest `o_pq_wrt` at T+2. Pop accepted at T → earliest strobe at T+2, and `o_pop_valid` one cycle after the strobe.
- **Empty pop:** `o_pop_valid` at T+2 with no strobe.
- **Reset (asynchronous):**
  - All outputs go to 0 except `o_push_ready`=1 and `o_pop_ready`=1.
  - FIFO and pending pop are cleared, the state goes to `IDLE` and the counter to 0.
  - Reset mid-`WAIT` aborts without any further strobe; the queue shares the reset.
- **FIFO:** simultaneous push-accept and FIFO-pop when full is legal; count is unchanged and pointers wrap modulo `FIFO_DEPTH`.
- **Status inputs:** `i_pq_full`/`i_pq_empty` are only sampled in `IDLE`, after the wait has elapsed.

## Structure
- **`pq_cmd_pkg`:**
  - `pq_op_t` enum {OP_NONE, OP_ENQ, OP_DEQ, OP_REP}.
  - `sched_state_t` enum {IDLE, WAIT}.
  - Wait-counter width function `$clog2(max(ENQ_WAIT, OP_WAIT)+1)`.
- **`pq_cmd_fifo`:** one sub-module; synchronous FIFO, `DATA_WIDTH` × `FIFO_DEPTH`, with full/empty/count and async active-low reset.

## Test plan
All scenarios use `QUEUE_SIZE`=8, `ENQ_WAIT`=4, with `RegisterArray` (`ENQ_ENA`=1) as the load.
- **Reset:** assert `i_RSTn`=0 mid-run → all strobes 0, `o_pop_valid`=0, `o_push_ready`=`o_pop_ready`=1, and no strobe for 3 cycles after release.
- **Back-to-back pushes:** pushes 5, 9, 3 → `o_pq_wrt` pulses exactly 5 cycles apart with data 5, 9, 3, and queue top becomes 9.
- **Dequeue:** top=9, FIFO empty, pop → single `o_pq_read` pulse; next cycle `o_pop_valid`=1, `o_pop_data`=9, `o_pop_empty`=0, and new top 5.
- **Merged replace:** top=9, pop and push 7 in the same cycle → one wrt+read strobe with data 7, `o_pop_data`=9, and queue becomes {7, 5, 3}.
- **Empty-queue pop:** queue empty, FIFO empty, pop → no strobe; `o_pop_valid`=1, `o_pop_empty`=1, `o_pop_data`=0.
- **Full queue, then pop:**
  - Queue filled to 8, then 5 more pushes → no wrt strobes, `o_push_ready` drops after 4 are accepted.
  - A pop then yields a replace using the oldest buffered key, and `o_push_ready` returns to 1.
